// File: rtl/ffd_pipe_ena_pkg.sv
// Common helpers shared by the ffd_pipe_ena pipeline register files.
package ffd_pipe_ena_pkg;

  // Ceiling log2, usable in constant expressions for port widths.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ffd_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data word that load when
// the stage advances; data only loads when a valid word arrives.
module ffd_pipe_stage #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iFlush,
  input  logic             iAdv,
  input  logic             iValid,
  input  logic [WIDTH-1:0] iD,
  output logic             oValid,
  output logic [WIDTH-1:0] oQ
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  // NOTE: every always_comb output gets a hold-value default first so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (iFlush) begin
      valid_d = 1'b0;
    end else if (iAdv) begin
      valid_d = iValid;
      if (iValid) data_d = iD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. The data word is
  // reset too, so oQ shows RST_VALUE until the first word reaches the output.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      valid_q <= 1'b0;
      data_q  <= RST_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign oValid = valid_q;
  assign oQ     = data_q;

endmodule

// File: rtl/ffd_pipe_ena.sv
// Elastic valid/ready pipeline register of DEPTH stages with flush and an
// occupancy counter; the ready chain is a pure combinational ripple.
module ffd_pipe_ena
  import ffd_pipe_ena_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic                          iClk,
  input  logic                          iRst_n,
  input  logic                          iValid,
  output logic                          oReady,
  input  logic [WIDTH-1:0]              iD,
  input  logic                          iFlush,
  output logic                          oValid,
  input  logic                          iReady,
  output logic [WIDTH-1:0]              oQ,
  output logic [clog2(DEPTH+1)-1:0]     oLevel
);

  localparam int LW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] stage_v;
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [LW-1:0]    level_d, level_q;

  // A stage may take new content when it is empty or its successor moves.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = !stage_v[DEPTH-1] || iReady;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !stage_v[k] || adv[k+1];
    end
  end

  assign oReady   = adv[0] && !iFlush;
  assign in_xfer  = iValid && oReady;
  assign out_xfer = oValid && iReady;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_d;

    if (k == 0) begin : g_head
      assign src_valid = in_xfer;
      assign src_d     = iD;
    end else begin : g_body
      assign src_valid = stage_v[k-1];
      assign src_d     = stage_d[k-1];
    end

    ffd_pipe_stage #(
      .WIDTH     (WIDTH),
      .RST_VALUE (RST_VALUE)
    ) u_stage (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iFlush (iFlush),
      .iAdv   (adv[k]),
      .iValid (src_valid),
      .iD     (src_d),
      .oValid (stage_v[k]),
      .oQ     (stage_d[k])
    );
  end

  // A flush empties the pipe even if the head word is delivered that cycle.
  always_comb begin
    level_d = level_q;
    if (iFlush) begin
      level_d = '0;
    end else if (in_xfer && !out_xfer) begin
      level_d = level_q + LW'(1);
    end else if (out_xfer && !in_xfer) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign oValid = stage_v[DEPTH-1];
  assign oQ     = stage_d[DEPTH-1];
  assign oLevel = level_q;

endmodule

// File: tb/tb_ffd_pipe_ena.sv
// Bench for ffd_pipe_ena: directed vector table, hand sequences for reset
// corners, then random traffic against a word/position queue model.
module tb_ffd_pipe_ena;

  localparam int          WIDTH = 8;
  localparam int          DEPTH = 3;
  localparam logic [7:0]  RSTV  = 8'hA5;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic       iValid;
  logic       oReady;
  logic [7:0] iD;
  logic       iFlush;
  logic       oValid;
  logic       iReady;
  logic [7:0] oQ;
  logic [1:0] oLevel;

  int n_cmp  = 0;
  int n_fail = 0;

  ffd_pipe_ena #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RST_VALUE (RSTV)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iValid (iValid),
    .oReady (oReady),
    .iD     (iD),
    .iFlush (iFlush),
    .oValid (oValid),
    .iReady (iReady),
    .oQ     (oQ),
    .oLevel (oLevel)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic rst_n, input logic valid, input logic [7:0] d,
                       input logic flush, input logic ready);
    @(negedge iClk);
    iRst_n = rst_n;
    iValid = valid;
    iD     = d;
    iFlush = flush;
    iReady = ready;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_ready, input logic e_valid,
                            input logic [7:0] e_q, input logic [1:0] e_lvl);
    check({tag, ".oReady"}, 32'(oReady), 32'(e_ready));
    check({tag, ".oValid"}, 32'(oValid), 32'(e_valid));
    check({tag, ".oQ"},     32'(oQ),     32'(e_q));
    check({tag, ".oLevel"}, 32'(oLevel), 32'(e_lvl));
  endtask

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] d;
    logic       flush;
    logic       ready;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_q;
    logic [1:0] e_lvl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic f, logic rdy,
                              logic er, logic ev, logic [7:0] eq, logic [1:0] el);
    vec_t t;
    t.rst_n = r;  t.valid = v;  t.d = d;  t.flush = f;  t.ready = rdy;
    t.e_ready = er; t.e_valid = ev; t.e_q = eq; t.e_lvl = el;
    return t;
  endfunction

  // Reference model: queue of in-flight words, oldest first, each with its stage position.
  int         m_pos[$];
  logic [7:0] m_w[$];
  bit         m_mv[$];
  logic [7:0] m_last;

  task automatic model_comb(input logic ready, input logic flush, output logic acc);
    m_mv.delete();
    for (int i = 0; i < m_pos.size(); i++) begin
      if (i == 0) m_mv.push_back((m_pos[0] == DEPTH - 1) ? bit'(ready) : 1'b1);
      else        m_mv.push_back((m_pos[i-1] > m_pos[i] + 1) || m_mv[i-1]);
    end
    if (flush) acc = 1'b0;
    else if (m_pos.size() == 0) acc = 1'b1;
    else acc = (m_pos[m_pos.size()-1] > 0) || m_mv[m_pos.size()-1];
  endtask

  task automatic model_edge(input logic rst_n, input logic valid, input logic [7:0] d,
                            input logic flush, input logic acc);
    bit head_leaves;
    head_leaves = 1'b0;
    if (!rst_n) begin
      m_pos.delete(); m_w.delete(); m_last = RSTV;
    end else if (flush) begin
      m_pos.delete(); m_w.delete();
    end else begin
      for (int i = m_pos.size() - 1; i >= 0; i--) begin
        if (m_mv[i]) begin
          if (m_pos[i] == DEPTH - 1) head_leaves = 1'b1;
          else begin
            m_pos[i] = m_pos[i] + 1;
            if (m_pos[i] == DEPTH - 1) m_last = m_w[i];
          end
        end
      end
      if (head_leaves) begin
        void'(m_pos.pop_front());
        void'(m_w.pop_front());
      end
      if (valid && acc) begin
        m_pos.push_back(0);
        m_w.push_back(d);
        if (DEPTH == 1) m_last = d;
      end
    end
  endtask

  initial begin
    logic       acc;
    logic       r, v, f, rdy;
    logic [7:0] d;

    // Reset state after one edge with iRst_n low.
    iRst_n = 1'b0; iValid = 1'b0; iD = 8'h00; iFlush = 1'b0; iReady = 1'b0;
    @(posedge iClk);
    drive(1, 0, 8'h00, 0, 0);
    check_outs("reset", 1, 0, RSTV, 0);

    // Directed table: streaming, back-pressure, bubble collapse, flush, mid-stream reset.
    vq.push_back(mk(1,1,8'h01,0,1, 1,0,8'hA5,0));
    vq.push_back(mk(1,1,8'h02,0,1, 1,0,8'hA5,1));
    vq.push_back(mk(1,1,8'h03,0,1, 1,0,8'hA5,2));
    vq.push_back(mk(1,1,8'h04,0,1, 1,1,8'h01,3));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h02,3));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h03,2));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h04,1));
    vq.push_back(mk(1,1,8'h10,0,0, 1,0,8'h04,0));
    vq.push_back(mk(1,1,8'h11,0,0, 1,0,8'h04,1));
    vq.push_back(mk(1,1,8'h12,0,0, 1,0,8'h04,2));
    vq.push_back(mk(1,1,8'h13,0,0, 0,1,8'h10,3));
    vq.push_back(mk(1,1,8'h13,0,0, 0,1,8'h10,3));
    vq.push_back(mk(1,1,8'h13,0,1, 1,1,8'h10,3));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h11,3));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h12,2));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h13,1));
    vq.push_back(mk(1,1,8'h20,0,0, 1,0,8'h13,0));
    vq.push_back(mk(1,0,8'h00,0,0, 1,0,8'h13,1));
    vq.push_back(mk(1,1,8'h21,0,0, 1,0,8'h13,1));
    vq.push_back(mk(1,0,8'h00,0,0, 1,1,8'h20,2));
    vq.push_back(mk(1,0,8'h00,0,0, 1,1,8'h20,2));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h20,2));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h21,1));
    vq.push_back(mk(1,1,8'h30,0,0, 1,0,8'h21,0));
    vq.push_back(mk(1,1,8'h31,0,0, 1,0,8'h21,1));
    vq.push_back(mk(1,1,8'h32,0,0, 1,0,8'h21,2));
    vq.push_back(mk(1,1,8'h33,1,1, 0,1,8'h30,3));
    vq.push_back(mk(1,0,8'h00,0,1, 1,0,8'h30,0));
    vq.push_back(mk(1,1,8'h40,0,0, 1,0,8'h30,0));
    vq.push_back(mk(1,1,8'h41,0,0, 1,0,8'h30,1));
    vq.push_back(mk(1,1,8'h42,0,0, 1,0,8'h30,2));
    vq.push_back(mk(0,1,8'h43,0,0, 0,1,8'h40,3));
    vq.push_back(mk(1,1,8'h50,0,1, 1,0,8'hA5,0));
    vq.push_back(mk(1,0,8'h00,0,1, 1,0,8'hA5,1));
    vq.push_back(mk(1,0,8'h00,0,1, 1,0,8'hA5,1));
    vq.push_back(mk(1,0,8'h00,0,1, 1,1,8'h50,1));
    vq.push_back(mk(1,0,8'h00,0,1, 1,0,8'h50,0));

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].valid, vq[i].d, vq[i].flush, vq[i].ready);
      check_outs($sformatf("vec%0d", i), vq[i].e_ready, vq[i].e_valid, vq[i].e_q, vq[i].e_lvl);
    end

    // Reset pulse between edges must not disturb state.
    drive(1, 1, 8'h60, 0, 0);
    drive(1, 0, 8'h00, 0, 0);
    iRst_n = 1'b0;
    #2;
    iRst_n = 1'b1;
    #1;
    check_outs("midpulse", 1, 0, 8'h50, 1);
    drive(1, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0);
    check_outs("midpulse_after", 1, 1, 8'h60, 1);

    // Random traffic against the model, starting from a clean reset.
    drive(0, 0, 8'h00, 0, 0);
    m_pos.delete(); m_w.delete(); m_last = RSTV;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) != 0);
      v   = ($urandom_range(0, 9) < 7);
      d   = 8'($urandom);
      f   = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      drive(r, v, d, f, rdy);
      model_comb(rdy, f, acc);
      check_outs($sformatf("rnd%0d", c), acc,
                 (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1),
                 m_last, 2'(m_pos.size()));
      model_edge(r, v, d, f, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ffd_pipe_ena.md
Name: ffd_pipe_ena

Overview:
- Parametrised successor to the single-stage enabled D flip-flop: an elastic pipeline register of DEPTH stages, each WIDTH bits wide.
- Uses a valid/ready handshake instead of a bare enable, so a stalled consumer back-pressures the producer without losing data.
- Adds a synchronous flush and an occupancy count.
- Used on CPLD datapaths (SMBus/SPI filtering, sequencer event paths) that need registered delay tolerant of consumer stalls.

Parameters:
- RST_VALUE, 0, value loaded into every stage data register on reset.
- WIDTH, 1, data width in bits; legal range ≥1.
- DEPTH, 2, number of register stages; legal range ≥1; no-stall latency in cycles.

Ports:
- iClk  input  1  clock; all state changes on its rising edge.
- iRst_n  input  1  synchronous active-low reset, sampled on rising edge of iClk.
- iValid  input  1  upstream data valid.
- oReady  output  1  upstream may transfer; transfer occurs when iValid && oReady.
- iD  input  WIDTH  upstream data.
- iFlush  input  1  synchronous flush, active high.
- oValid  output  1  stage DEPTH-1 holds valid data.
- iReady  input  1  downstream accepts; transfer occurs when oValid && iReady.
- oQ  output  WIDTH  data of stage DEPTH-1.
- oLevel  output  $clog2(DEPTH+1)  count of valid stages, 0..DEPTH.

Behaviour:
- Reset is synchronous and active-low. Only a rising iClk edge with iRst_n=0 resets; iRst_n low between edges has no effect.
- On reset: all stage valid bits = 0, all stage data = RST_VALUE, so oQ = RST_VALUE, oValid = 0, oLevel = 0. Reset overrides flush and handshakes.
- Stage k has valid v[k] and data d[k]. Stage 0 is the input; stage DEPTH-1 drives oValid/oQ.
- Advance rule (combinational): adv[DEPTH-1] = !v[DEPTH-1] || iReady; adv[k] = !v[k] || adv[k+1]. oReady = adv[0] && !iFlush.
- When adv[k]=1 on an edge:
  - d[k] <= d[k-1] and v[k] <= v[k-1]; for stage 0 the source is iD / (iValid && oReady).
  - d[k] loads only when the incoming valid is 1; otherwise d[k] holds its value and only v[k] clears.
- When adv[k]=0, stage k holds d[k] and v[k].
- Throughput: 1 word per cycle with iReady held high. Latency from accepted iD to oValid is exactly DEPTH cycles.
- Bubbles collapse: an empty stage accepts even while downstream stages are stalled.
- Full condition: all v=1 and iReady=0 → oReady=0, all state frozen.
- Simultaneous output transfer and input transfer while full: allowed. The chain shifts and oLevel is unchanged.
- oLevel is a registered counter:
  - +1 on input transfer only; −1 on output transfer only; unchanged when both or neither occur.
  - Never exceeds DEPTH and never underflows.
- iFlush=1 at an edge:
  - all v <= 0 and oLevel <= 0; data registers hold their values.
  - oReady is forced 0 that cycle, so no input is accepted.
  - An output transfer (oValid && iReady) in the same cycle still completes for the consumer, and the word is counted as delivered.
- oQ shows the last loaded data even while oValid=0; consumers qualify it with oValid.
- The ready chain is a combinational path of length DEPTH. Implementation must remain a pure ripple; no skid registers.

Decomposition:
- Shared package (existing common package): a clog2 constant function for the oLevel width. No new typedefs.
- One natural sub-module, ffd_pipe_stage: a single valid+data register with its advance logic, instantiated DEPTH times with a generate loop.
- The top level holds the ready chain, flush gating and the oLevel counter.

Test Plan:
- Reset (WIDTH=8, DEPTH=3, RST_VALUE=8'hA5): hold iRst_n=0 one edge → oQ=8'hA5, oValid=0, oLevel=0, oReady=1. Drive iRst_n low mid-cycle with no edge → no state change.
- Streaming: iReady=1, iValid=1, iD=8'h01,02,03,04 on consecutive cycles → oValid rises 3 cycles after first accept. oQ = 01,02,03,04 on consecutive cycles. oLevel holds at 3.
- Back-pressure: iReady=0, push 8'h10,11,12 → oLevel=3, oReady=0, and a fourth push of 8'h13 is not accepted. Raise iReady → outputs 10,11,12 in order; 8'h13 is accepted on the first cycle oReady=1.
- Bubble collapse: push 8'h20, idle one cycle, push 8'h21 with iReady=0 → both words occupy the last two stages and oLevel=2. Release iReady → 20 then 21 on consecutive cycles.
- Flush: pipeline holds 3 words with iReady=1 and iValid=1 at the flush edge → the head word delivers that cycle. The input word is not accepted (oReady=0). Next cycle oValid=0 and oLevel=0.
- Reset mid-stream: iRst_n=0 for one edge while full and stalled → all cleared, oQ=RST_VALUE. After iRst_n returns to 1, normal streaming resumes with latency 3.
